imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time writer for the instruction memory that the single-cycle core reads at its PC. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into instruction memory through a write port, and holds the core in reset until the image is fully loaded.

Parameters:
DEPTH_WORDS, 64, instruction memory capacity in 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
CNT_W, $clog2(DEPTH_WORDS+1), width of the word-count input. Derived; do not override.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_srst  input  1  synchronous, active-high reset.
i_start  input  1  one-cycle load request; sampled only in IDLE, DONE and ERROR.
i_wordCount  input  CNT_W  number of words to load; latched when i_start is accepted.
i_byteValid  input  1  stream byte valid.
i_byte  input  8  stream byte.
o_byteReady  output  1  loader accepts a byte this cycle.
o_imemWriteEn  output  1  instruction memory write strobe.
o_imemWriteAddress  output  32  byte address of the word being written.
o_imemWriteData  output  32  assembled instruction word.
o_coreReset  output  1  holds the core (PC) in reset.
o_busy  output  1  load in progress.
o_done  output  1  image loaded successfully.
o_error  output  1  load rejected or failed.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_srst is synchronous and active-high.
- Reset values: state IDLE; o_byteReady=0, o_imemWriteEn=0, o_imemWriteAddress=0, o_imemWriteData=0, o_coreReset=1, o_busy=0, o_done=0, o_error=0; internal byte index, word index and checksum all 0.
- Registered outputs: all outputs are registered except o_byteReady, which decodes the current state.
- FSM states: IDLE, LOAD, CHECK (present only when the optional feature is compiled in), DONE, ERROR.
- IDLE, DONE, ERROR on i_start:
  - i_wordCount==0 or i_wordCount>DEPTH_WORDS -> ERROR next cycle.
  - Otherwise latch the count, clear the indices and checksum, and go to LOAD.
  - o_coreReset=1 from the next cycle.
- LOAD:
  - o_byteReady=1 and o_busy=1.
  - A byte transfers on the cycle where i_byteValid && o_byteReady are both high.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k] of that word.
  - On the 4th byte transfer: in the following cycle o_imemWriteEn=1 for exactly one cycle, o_imemWriteAddress=BASE_ADDR+4*wordIndex, and o_imemWriteData holds the assembled word. The word index then increments.
  - Back-to-back bytes (one per cycle) are sustained. The assembly register and the write-data register are separate, so the write pulse overlaps acceptance of the next word's byte 0.
  - After the last word's 4th byte, go to DONE, or to CHECK when the optional feature is compiled in.
- i_start is ignored in LOAD and CHECK. i_byteValid is ignored outside LOAD and CHECK.
- DONE: o_done=1, o_coreReset=0, o_busy=0, o_byteReady=0. The state persists until i_start or i_srst.
- ERROR: o_error=1, o_coreReset=1, o_busy=0, no writes. i_start retries the load.
- o_done and o_error clear on the cycle after i_start is accepted.
- Reset mid-load: all registers return to reset values on the next edge. A partial word is discarded. Words already written stay in memory, and no further write strobe is issued.
- Write address wrap is impossible, because the count is bounded by DEPTH_WORDS.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN:
- Defined:
  - During LOAD, an 8-bit running sum (mod 256) of all accepted data bytes is kept.
  - After the last word the FSM enters CHECK with o_byteReady=1 and accepts exactly one checksum byte.
  - Equal to the running sum -> DONE. Otherwise -> ERROR with o_coreReset held at 1.
- Undefined: the CHECK state and the running sum are absent, and LOAD goes directly to DONE.

Test Plan:
1. i_start with i_wordCount=2; bytes 13 05 A0 00 93 05 10 00 streamed back-to-back -> two write pulses: 0x00A00513 at address 0x0, then 0x00100593 at address 0x4, each one cycle after its 4th byte. Then o_done=1, o_coreReset=0, o_byteReady=0.
2. Same image with i_byteValid toggling randomly -> identical writes, exactly two o_imemWriteEn pulses, and no byte lost or duplicated.
3. i_wordCount=0, and separately i_wordCount=65 with DEPTH_WORDS=64 -> o_error=1 next cycle, o_coreReset=1, no write pulses. A subsequent valid i_start loads normally.
4. i_srst after 6 accepted bytes of test 1 -> only word 0 is written. All outputs equal reset values on the next cycle, and no write pulse for the partial word.
5. With IMEM_LOADER_CHECKSUM_EN, test 1 followed by checksum 0x60 -> DONE. Followed by 0x61 -> ERROR, o_coreReset=1, o_done=0.
6. i_start pulsed mid-LOAD -> ignored, load completes unchanged. i_start in DONE -> o_coreReset=1 and o_done=0 next cycle, and a new load begins at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a byte stream over valid/ready, packs little-endian 32-bit words,
// writes each one through the instruction memory write port, and keeps the
// core in reset until the whole image is in place.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit
// checksum byte (sum mod 256 of all image bytes) that must match before the
// core is released.
module imem_loader #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_wordCount,
  input  logic             i_byteValid,
  input  logic [7:0]       i_byte,
  output logic             o_byteReady,
  output logic             o_imemWriteEn,
  output logic [31:0]      o_imemWriteAddress,
  output logic [31:0]      o_imemWriteData,
  output logic             o_coreReset,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd2;
`endif
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] wordCountReg;
  logic [CNT_W-1:0] wordIdx;
  logic [1:0]       byteIdx;
  logic [23:0]      asmReg;     // bytes 0..2 of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  logic canStart;
  logic countBad;
  logic lastWord;

  // Start requests are honoured only while no load is running.
  assign canStart = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign countBad = (i_wordCount == '0) || (32'(i_wordCount) > 32'(DEPTH_WORDS));
  assign lastWord = (wordIdx == wordCountReg - CNT_W'(1));

  // Ready is a pure state decode so the producer sees it in the same cycle.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign o_byteReady = (state == LOAD) || (state == CHECK);
`else
  assign o_byteReady = (state == LOAD);
`endif

  // Control FSM, byte assembly, write port and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      // NOTE: every register here sits in one reset branch and is assigned
      // with <=, so all of them see pre-edge values of each other.
      state              <= IDLE;
      wordCountReg       <= '0;
      wordIdx            <= '0;
      byteIdx            <= '0;
      asmReg             <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum           <= '0;
`endif
      o_imemWriteEn      <= 1'b0;
      o_imemWriteAddress <= '0;
      o_imemWriteData    <= '0;
      o_coreReset        <= 1'b1;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      o_imemWriteEn <= 1'b0;

      case (state)
        IDLE, DONE, ERROR: begin
          if (i_start && canStart) begin
            o_coreReset <= 1'b1;
            o_done      <= 1'b0;
            if (countBad) begin
              state   <= ERROR;
              o_error <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state        <= LOAD;
              wordCountReg <= i_wordCount;
              wordIdx      <= '0;
              byteIdx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              checksum     <= '0;
`endif
              o_error      <= 1'b0;
              o_busy       <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (i_byteValid) begin
            byteIdx <= byteIdx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= checksum + i_byte;
`endif
            case (byteIdx)
              2'd0: asmReg[7:0]   <= i_byte;
              2'd1: asmReg[15:8]  <= i_byte;
              2'd2: asmReg[23:16] <= i_byte;
              2'd3: begin
                // Write data has its own register, so the next word's
                // byte 0 can land in asmReg while this word is written.
                o_imemWriteEn      <= 1'b1;
                o_imemWriteAddress <= BASE_ADDR + (32'(wordIdx) << 2);
                o_imemWriteData    <= {i_byte, asmReg};
                wordIdx            <= wordIdx + CNT_W'(1);
                if (lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= CHECK;
`else
                  state       <= DONE;
                  o_done      <= 1'b1;
                  o_coreReset <= 1'b0;
                  o_busy      <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (i_byteValid) begin
            o_busy <= 1'b0;
            if (i_byte == checksum) begin
              state       <= DONE;
              o_done      <= 1'b1;
              o_coreReset <= 1'b0;
            end else begin
              state       <= ERROR;
              o_error     <= 1'b1;
              o_coreReset <= 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (DEPTH_WORDS=64, BASE_ADDR=0).
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             i_srst = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_wordCount = '0;
  logic             i_byteValid = 1'b0;
  logic [7:0]       i_byte = '0;
  logic             o_byteReady;
  logic             o_imemWriteEn;
  logic [31:0]      o_imemWriteAddress;
  logic [31:0]      o_imemWriteData;
  logic             o_coreReset;
  logic             o_busy;
  logic             o_done;
  logic             o_error;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0]  img [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
  logic [7:0]  txBytes [$];
  logic [31:0] wrAddr [$];
  logic [31:0] wrData [$];

  imem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .i_clk(clk), .i_srst(i_srst), .i_start(i_start), .i_wordCount(i_wordCount),
    .i_byteValid(i_byteValid), .i_byte(i_byte), .o_byteReady(o_byteReady),
    .o_imemWriteEn(o_imemWriteEn), .o_imemWriteAddress(o_imemWriteAddress),
    .o_imemWriteData(o_imemWriteData), .o_coreReset(o_coreReset),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_imemWriteEn === 1'b1) begin
      wrAddr.push_back(o_imemWriteAddress);
      wrData.push_back(o_imemWriteData);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input logic [CNT_W-1:0] n);
    i_start = 1'b1;
    i_wordCount = n;
    step();
    i_start = 1'b0;
  endtask

  task automatic clearWrites();
    wrAddr.delete();
    wrData.delete();
  endtask

  // Queue the 8-byte test image, plus its checksum when that feature exists.
  task automatic queueImage(input logic [7:0] cs);
    txBytes.delete();
    for (int i = 0; i < 8; i++) txBytes.push_back(img[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    txBytes.push_back(cs);
`endif
  endtask

  // Push txBytes through the handshake, optionally with random valid gaps.
  task automatic streamBytes(input bit gaps);
    int idx = 0;
    int cyc = 0;
    bit fire;
    while (idx < txBytes.size() && cyc < 400) begin
      i_byteValid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      i_byte = i_byteValid ? txBytes[idx] : 8'($urandom);
      fire = i_byteValid && o_byteReady;
      step();
      if (fire) idx++;
      cyc++;
    end
    i_byteValid = 1'b0;
    nChecks++; if (idx != txBytes.size()) begin nFails++; $display("FAIL stream_timeout: sent %0d bytes expected %0d", idx, txBytes.size()); end
  endtask

  task automatic checkImageWrites(input string tag);
    nChecks++; if (wrData.size() != 2) begin nFails++; $display("FAIL %s_wrcount: got %0d expected 2", tag, wrData.size()); end
    if (wrData.size() == 2) begin
      nChecks++; if (wrAddr[0] !== 32'h0 || wrData[0] !== 32'h00A00513) begin nFails++; $display("FAIL %s_w0: got %h@%h expected 00a00513@00000000", tag, wrData[0], wrAddr[0]); end
      nChecks++; if (wrAddr[1] !== 32'h4 || wrData[1] !== 32'h00100593) begin nFails++; $display("FAIL %s_w1: got %h@%h expected 00100593@00000004", tag, wrData[1], wrAddr[1]); end
    end
  endtask

  task automatic checkDone(input string tag);
    nChecks++; if (o_done !== 1'b1) begin nFails++; $display("FAIL %s_done: got %b expected 1", tag, o_done); end
    nChecks++; if (o_coreReset !== 1'b0) begin nFails++; $display("FAIL %s_coreReset: got %b expected 0", tag, o_coreReset); end
    nChecks++; if (o_byteReady !== 1'b0 || o_busy !== 1'b0 || o_error !== 1'b0) begin nFails++; $display("FAIL %s_idleflags: ready/busy/error got %b%b%b expected 000", tag, o_byteReady, o_busy, o_error); end
  endtask

  task automatic test_reset();
    i_srst = 1'b1;
    step();
    step();
    nChecks++; if (o_coreReset !== 1'b1) begin nFails++; $display("FAIL rst_coreReset: got %b expected 1", o_coreReset); end
    nChecks++; if ({o_byteReady, o_imemWriteEn, o_busy, o_done, o_error} !== 5'b0) begin nFails++; $display("FAIL rst_flags: got %b expected 00000", {o_byteReady, o_imemWriteEn, o_busy, o_done, o_error}); end
    nChecks++; if (o_imemWriteAddress !== 32'h0 || o_imemWriteData !== 32'h0) begin nFails++; $display("FAIL rst_wrport: got %h/%h expected 0/0", o_imemWriteAddress, o_imemWriteData); end
    i_srst = 1'b0;
    step();
  endtask

  // Back-to-back stream with per-cycle write pulse timing.
  task automatic test_basic_load();
    clearWrites();
    startLoad(7'd2);
    nChecks++; if (o_busy !== 1'b1 || o_byteReady !== 1'b1 || o_coreReset !== 1'b1) begin nFails++; $display("FAIL t1_loadstate: busy/ready/coreReset got %b%b%b expected 111", o_busy, o_byteReady, o_coreReset); end
    for (int k = 0; k < 8; k++) begin
      i_byteValid = 1'b1;
      i_byte = img[k];
      step();
      nChecks++; if (o_imemWriteEn !== ((k % 4) == 3)) begin nFails++; $display("FAIL t1_we_byte%0d: got %b expected %b", k, o_imemWriteEn, (k % 4) == 3); end
      if (k == 3) begin
        nChecks++; if (o_imemWriteAddress !== 32'h0 || o_imemWriteData !== 32'h00A00513) begin nFails++; $display("FAIL t1_word0: got %h@%h expected 00a00513@00000000", o_imemWriteData, o_imemWriteAddress); end
      end
      if (k == 7) begin
        nChecks++; if (o_imemWriteAddress !== 32'h4 || o_imemWriteData !== 32'h00100593) begin nFails++; $display("FAIL t1_word1: got %h@%h expected 00100593@00000004", o_imemWriteData, o_imemWriteAddress); end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    nChecks++; if (o_done !== 1'b0 || o_byteReady !== 1'b1) begin nFails++; $display("FAIL t1_check_wait: done/ready got %b%b expected 01", o_done, o_byteReady); end
    i_byte = 8'h60;
    step();
`endif
    i_byteValid = 1'b0;
    checkDone("t1");
    step();
    checkImageWrites("t1");
  endtask

  task automatic test_random_valid();
    clearWrites();
    startLoad(7'd2);
    queueImage(8'h60);
    streamBytes(1'b1);
    step();
    checkImageWrites("t2");
    checkDone("t2");
  endtask

  task automatic test_bad_count();
    clearWrites();
    startLoad(7'd0);
    nChecks++; if (o_error !== 1'b1 || o_coreReset !== 1'b1 || o_done !== 1'b0) begin nFails++; $display("FAIL t3_zero: error/coreReset/done got %b%b%b expected 110", o_error, o_coreReset, o_done); end
    nChecks++; if (o_busy !== 1'b0 || o_byteReady !== 1'b0) begin nFails++; $display("FAIL t3_zero_idle: busy/ready got %b%b expected 00", o_busy, o_byteReady); end
    for (int k = 0; k < 6; k++) begin
      i_byteValid = 1'b1;
      i_byte = img[k];
      step();
    end
    i_byteValid = 1'b0;
    startLoad(7'd65);
    nChecks++; if (o_error !== 1'b1 || o_coreReset !== 1'b1) begin nFails++; $display("FAIL t3_over: error/coreReset got %b%b expected 11", o_error, o_coreReset); end
    step();
    nChecks++; if (wrData.size() != 0) begin nFails++; $display("FAIL t3_nowrites: got %0d writes expected 0", wrData.size()); end
    startLoad(7'd2);
    nChecks++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin nFails++; $display("FAIL t3_retry: error/busy got %b%b expected 01", o_error, o_busy); end
    queueImage(8'h60);
    streamBytes(1'b0);
    step();
    checkImageWrites("t3");
    checkDone("t3");
  endtask

  task automatic test_reset_mid_load();
    clearWrites();
    startLoad(7'd2);
    for (int k = 0; k < 6; k++) begin
      i_byteValid = 1'b1;
      i_byte = img[k];
      step();
    end
    i_byte = img[6];
    i_srst = 1'b1;
    step();
    nChecks++; if ({o_byteReady, o_imemWriteEn, o_busy, o_done, o_error, o_coreReset} !== 6'b000001) begin nFails++; $display("FAIL t4_flags: got %b expected 000001", {o_byteReady, o_imemWriteEn, o_busy, o_done, o_error, o_coreReset}); end
    nChecks++; if (o_imemWriteAddress !== 32'h0 || o_imemWriteData !== 32'h0) begin nFails++; $display("FAIL t4_wrport: got %h/%h expected 0/0", o_imemWriteAddress, o_imemWriteData); end
    i_srst = 1'b0;
    for (int k = 0; k < 4; k++) step();
    i_byteValid = 1'b0;
    step();
    nChecks++; if (wrData.size() != 1) begin nFails++; $display("FAIL t4_wrcount: got %0d expected 1", wrData.size()); end
    if (wrData.size() >= 1) begin
      nChecks++; if (wrData[0] !== 32'h00A00513 || wrAddr[0] !== 32'h0) begin nFails++; $display("FAIL t4_word0: got %h@%h expected 00a00513@00000000", wrData[0], wrAddr[0]); end
    end
  endtask

  task automatic test_start_ignored_and_restart();
    clearWrites();
    startLoad(7'd2);
    for (int k = 0; k < 8; k++) begin
      i_byteValid = 1'b1;
      i_byte = img[k];
      i_start = (k == 3 || k == 5);
      i_wordCount = 7'd1;
      step();
    end
    i_start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    i_byte = 8'h60;
    step();
`endif
    i_byteValid = 1'b0;
    step();
    checkImageWrites("t6");
    checkDone("t6");
    clearWrites();
    startLoad(7'd1);
    nChecks++; if (o_coreReset !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b1) begin nFails++; $display("FAIL t6_restart: coreReset/done/busy got %b%b%b expected 101", o_coreReset, o_done, o_busy); end
    txBytes.delete();
    txBytes.push_back(8'h44);
    txBytes.push_back(8'h33);
    txBytes.push_back(8'h22);
    txBytes.push_back(8'h11);
`ifdef IMEM_LOADER_CHECKSUM_EN
    txBytes.push_back(8'hAA);
`endif
    streamBytes(1'b0);
    step();
    nChecks++; if (wrData.size() != 1) begin nFails++; $display("FAIL t6_reload_count: got %0d expected 1", wrData.size()); end
    if (wrData.size() >= 1) begin
      nChecks++; if (wrData[0] !== 32'h11223344 || wrAddr[0] !== 32'h0) begin nFails++; $display("FAIL t6_reload_word: got %h@%h expected 11223344@00000000", wrData[0], wrAddr[0]); end
    end
    checkDone("t6b");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    clearWrites();
    startLoad(7'd2);
    queueImage(8'h61);
    streamBytes(1'b0);
    step();
    checkImageWrites("t5");
    nChecks++; if (o_error !== 1'b1 || o_coreReset !== 1'b1 || o_done !== 1'b0) begin nFails++; $display("FAIL t5_bad_cs: error/coreReset/done got %b%b%b expected 110", o_error, o_coreReset, o_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_random_valid();
    test_bad_count();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_start_ignored_and_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
